// File: rtl/seg_display_ctrl.sv
// Memory-mapped 7-segment display controller: MMIO decode, display buffering, on/off/blink/hold.
// Optional idle auto-off is compiled in when SEG_AUTO_OFF_EN is defined.
module seg_display_ctrl #(
    parameter logic [31:0] DATA_ADDR       = 32'hFFFF_FC60,
    parameter logic [31:0] CTRL_ADDR       = 32'hFFFF_FC64,
    parameter logic [31:0] STAT_ADDR       = 32'hFFFF_FC68,
    parameter int unsigned BLINK_CYCLES    = 25_000_000,
    parameter int unsigned AUTO_OFF_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_wen,
    input  logic        io_ren,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic [31:0] num,
    output logic        enable
);

    localparam int unsigned CW = $clog2(BLINK_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_BLANK
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0]   data_reg;
    logic [2:0]    ctrl;
    logic          pending;
    logic          restart;
    logic [31:0]   rdata_next;

    logic data_sel, ctrl_sel, stat_sel;
    logic data_wr, ctrl_wr;

    assign data_sel = (io_addr == DATA_ADDR);
    assign ctrl_sel = (io_addr == CTRL_ADDR);
    assign stat_sel = (io_addr == STAT_ADDR);
    assign data_wr  = io_wen && data_sel;
    assign ctrl_wr  = io_wen && ctrl_sel;

    // Load data is taken from pre-edge register values, so a simultaneous store is not visible.
    always_comb begin
        rdata_next = '0;
        if (data_sel)
            rdata_next = data_reg;
        else if (ctrl_sel)
            rdata_next = {29'b0, ctrl};
        else if (stat_sel)
            rdata_next = {30'b0, pending, enable};
    end

`ifdef SEG_AUTO_OFF_EN
    localparam int unsigned IW = $clog2(AUTO_OFF_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(AUTO_OFF_CYCLES);

    logic [IW-1:0] idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle <= '0;
        end else if (data_wr || ctrl_wr) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + IW'(1);
        end
    end

    logic auto_off;
    assign auto_off = !(data_wr || ctrl_wr) && (idle == IDLE_MAX - IW'(1));
`else
    logic auto_off;
    assign auto_off = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
            num      <= '0;
            ctrl     <= '0;
            pending  <= 1'b0;
            io_rdata <= '0;
            restart  <= 1'b0;
        end else begin
            restart <= ctrl_wr;
            if (io_ren)
                io_rdata <= rdata_next;
            if (data_wr) begin
                data_reg <= io_wdata;
                if (ctrl[2])
                    pending <= 1'b1;
                else
                    num <= io_wdata;
            end
            if (ctrl_wr) begin
                ctrl <= io_wdata[2:0];
                if (ctrl[2] && !io_wdata[2] && pending) begin
                    num     <= data_reg;
                    pending <= 1'b0;
                end
            end else if (auto_off) begin
                ctrl[0] <= 1'b0;
            end
        end
    end

    // FSM reacts one edge after the CTRL store, using the registered ctrl and restart flag.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!ctrl[0]) begin
            state_next = ST_OFF;
            cnt_next   = '0;
        end else if (state == ST_OFF || restart) begin
            state_next = ST_ON;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_ON: begin
                    if (!ctrl[1]) begin
                        cnt_next = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_BLANK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (!ctrl[1] || cnt == CNT_LAST) begin
                        state_next = ST_ON;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_OFF;
            cnt    <= '0;
            enable <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= ctrl_wr ? '0 : cnt_next;
            enable <= (state_next == ST_ON);
        end
    end

endmodule
